regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port CLR  input  1  reset; asynchronous, active-low (0 = clear).
REQ-004 SHALL have port a_valid  input  1  requester A (ALU writeback) has a write.
REQ-005 SHALL have port a_addr  input  4  requester A destination register.
REQ-006 SHALL have port a_data  input  DATA_W  requester A write data.
REQ-007 SHALL have port a_ready  output  1  A's write accepted this cycle.
REQ-008 SHALL have port b_valid  input  1  requester B (load writeback) has a write.
REQ-009 SHALL have port b_addr  input  4  requester B destination register.
REQ-010 SHALL have port b_data  input  DATA_W  requester B write data.
REQ-011 SHALL have port b_ready  output  1  B's write accepted this cycle.
REQ-012 SHALL have port writeAddress  output  4  register-file write address.
REQ-013 SHALL have port inputData  output  DATA_W  register-file write data.
REQ-014 SHALL have port RW  output  1  register-file control; 0 = write, 1 = read/idle.
REQ-015 SHALL have port issue_valid  input  1  an instruction claiming a destination issues.
REQ-016 SHALL have port issue_addr  input  4  destination claimed by issue.
REQ-017 SHALL have port addressA  input  4  source register being read on port A.
REQ-018 SHALL have port addressB  input  4  source register being read on port B.
REQ-019 SHALL have port hazardA  output  1  addressA has a pending write.
REQ-020 SHALL have port hazardB  output  1  addressB has a pending write.

Function
REQ-021 SHALL accept at most one write per cycle; handshake = valid & ready on the same rising edge.
REQ-022 SHALL drive a_ready/b_ready combinationally from valids and the last-grant pointer; never both high.
REQ-023 SHALL grant the sole valid requester when only one is valid.
REQ-024 SHALL, when both valid, grant the requester not granted last (round-robin); pointer updates only on a grant.
REQ-025 SHALL register the accepted write: next cycle RW=0, writeAddress/inputData = winner's addr/data (latency 1).
REQ-026 SHALL drive RW=1 in any cycle following a cycle with no grant; writeAddress/inputData hold last values.
REQ-027 SHALL sustain back-to-back writes at one per cycle with no idle bubble.
REQ-028 SHALL require requesters to hold valid/addr/data stable until ready; dropping valid before ready is permitted and discards nothing internally.
REQ-029 SHALL keep a 16-bit pending vector: issue_valid sets pending[issue_addr] on the rising edge.
REQ-030 SHALL clear pending[writeAddress] on the rising edge ending a cycle with RW=0.
REQ-031 SHALL, on simultaneous set and clear of the same bit, leave it set (new producer wins).
REQ-032 SHALL drive hazardA = pending[addressA], hazardB = pending[addressB], combinational from the registered vector.
REQ-033 SHALL treat register 15 identically to all others (no special PC handling).

Reset
REQ-034 SHALL, while CLR=0, force RW=1, writeAddress=0, inputData=0, pending=0, last-grant=B, a_ready=b_ready=0.
REQ-035 SHALL abandon an in-flight registered write on reset assertion; no write reaches the register file after CLR falls.
REQ-036 SHALL resume arbitration on the first rising edge after CLR returns to 1, A granted first on contention.

Configuration
REQ-037 SHALL include the pending vector and hazard logic only when REGFILE_SCOREBOARD_EN is defined.
REQ-038 SHALL, without REGFILE_SCOREBOARD_EN, tie hazardA=hazardB=0 and ignore issue_valid/issue_addr; arbitration unchanged.

Verification
REQ-039 SHALL cover: after reset, a_valid=1 a_addr=3 a_data=0x11 only -> a_ready=1; next cycle RW=0 writeAddress=3 inputData=0x11.
REQ-040 SHALL cover: a_valid=b_valid=1 held 4 cycles -> grants A,B,A,B; outputs RW=0 for 4 consecutive cycles.
REQ-041 SHALL cover: issue_addr=5 issued, addressA=5 -> hazardA=1 until cycle after write to 5 with RW=0, then 0.
REQ-042 SHALL cover: issue_addr=7 on same edge as RW=0 writeAddress=7 -> pending[7] stays 1, hazard persists.
REQ-043 SHALL cover: CLR pulsed low the cycle after a grant -> RW=1 during/after reset, pending=0, no write to register file.
REQ-044 SHALL cover: build without REGFILE_SCOREBOARD_EN, issue_addr=2 and addressB=2 -> hazardB=0 throughout.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Bundles the signals between the register-file write arbiter and the blocks
//   around it:
//     requester A (ALU writeback): a_valid, a_addr, a_data -> a_ready
//     requester B (load writeback): b_valid, b_addr, b_data -> b_ready
//     register-file write side:     writeAddress, inputData, RW (0 = write)
//     scoreboard:                   issue_valid, issue_addr, addressA/B -> hazardA/B
//   modport slave  : the arbiter
//   modport master : the surrounding pipeline / register file / testbench
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              a_valid;
  logic [3:0]        a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [3:0]        b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic [3:0]        writeAddress;
  logic [DATA_W-1:0] inputData;
  logic              RW;

  logic              issue_valid;
  logic [3:0]        issue_addr;
  logic [3:0]        addressA;
  logic [3:0]        addressB;
  logic              hazardA;
  logic              hazardB;

  modport slave (
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready,
    output writeAddress, inputData, RW,
    input  issue_valid, issue_addr, addressA, addressB,
    output hazardA, hazardB
  );

  modport master (
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready,
    input  writeAddress, inputData, RW,
    output issue_valid, issue_addr, addressA, addressB,
    input  hazardA, hazardB
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Round-robin arbiter merging two writeback requesters (A = ALU, B = load)
//   onto the single register-file write port, one write per cycle, latency 1.
//   Optional scoreboard (enabled by defining REGFILE_SCOREBOARD_EN) tracks
//   registers with an outstanding producer and flags read hazards.
// Ports:
//   CLK  - clock, rising edge
//   CLR  - asynchronous active-low reset
//   rf   - regfile_write_arbiter_if.slave (requesters, write port, scoreboard)
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input logic                   CLK,
  input logic                   CLR,
  regfile_write_arbiter_if.slave rf
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              rw_q, rw_d;
  logic [3:0]        waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_a, grant_b;

  // Readies are gated by CLR so nothing handshakes while reset is held.
  always_comb begin
    grant_a = CLR && rf.a_valid && (!rf.b_valid || (last_grant_q == GRANT_B));
    grant_b = CLR && rf.b_valid && !grant_a;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rw_d         = 1'b1;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    if (grant_a) begin
      last_grant_d = GRANT_A;
      rw_d         = 1'b0;
      waddr_d      = rf.a_addr;
      wdata_d      = rf.a_data;
    end else if (grant_b) begin
      last_grant_d = GRANT_B;
      rw_d         = 1'b0;
      waddr_d      = rf.b_addr;
      wdata_d      = rf.b_data;
    end
  end

  // Reset to last-grant = B so A wins the first contention after reset.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      last_grant_q <= GRANT_B;
      rw_q         <= 1'b1;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rw_q         <= rw_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign rf.a_ready      = grant_a;
  assign rf.b_ready      = grant_b;
  assign rf.RW           = rw_q;
  assign rf.writeAddress = waddr_q;
  assign rf.inputData    = wdata_q;

`ifdef REGFILE_SCOREBOARD_EN
  logic [15:0] pending_q, pending_d;

  // Clear is applied before set so a new producer issuing on the same edge
  // as the old producer's write keeps the register marked pending.
  always_comb begin
    pending_d = pending_q;
    if (!rw_q) begin
      pending_d[waddr_q] = 1'b0;
    end
    if (rf.issue_valid) begin
      pending_d[rf.issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rf.hazardA = pending_q[rf.addressA];
  assign rf.hazardB = pending_q[rf.addressB];
`else
  logic unused_scoreboard_inputs;
  assign unused_scoreboard_inputs = ^{rf.issue_valid, rf.issue_addr, rf.addressA, rf.addressB};

  assign rf.hazardA = 1'b0;
  assign rf.hazardB = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

`ifdef REGFILE_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic CLK;
  logic CLR;
  int unsigned checks;
  int unsigned failures;

  regfile_write_arbiter_if #(.DATA_W(32)) rf ();

  regfile_write_arbiter #(.DATA_W(32)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .rf  (rf.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic rw, input logic [3:0] wa, input logic [31:0] wd);
    chk({tag, "_rw"}, {31'd0, rf.RW}, {31'd0, rw});
    chk({tag, "_waddr"}, {28'd0, rf.writeAddress}, {28'd0, wa});
    chk({tag, "_wdata"}, rf.inputData, wd);
  endtask

  task automatic chk_rdy(input string tag, input logic ra, input logic rb);
    chk({tag, "_a_ready"}, {31'd0, rf.a_ready}, {31'd0, ra});
    chk({tag, "_b_ready"}, {31'd0, rf.b_ready}, {31'd0, rb});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    CLR         = 1'b0;
    rf.a_valid  = 1'b1;
    rf.a_addr   = 4'd3;
    rf.a_data   = 32'h11;
    rf.b_valid  = 1'b0;
    rf.b_addr   = '0;
    rf.b_data   = '0;
    rf.issue_valid = 1'b0;
    rf.issue_addr  = '0;
    rf.addressA    = 4'd5;
    rf.addressB    = 4'd7;

    // Reset state, requester A already valid but must not be accepted.
    repeat (2) @(negedge CLK);
    #1;
    chk_wr("reset", 1'b1, 4'd0, 32'h0);
    chk_rdy("reset", 1'b0, 1'b0);
    chk("reset_hazA", {31'd0, rf.hazardA}, 32'd0);

    // Sole A write after reset, latency 1, then idle with held values.
    @(negedge CLK);
    CLR = 1'b1;
    #1;
    chk_rdy("a_only", 1'b1, 1'b0);
    tick();
    rf.a_valid = 1'b0;
    chk_wr("a_only_wr", 1'b0, 4'd3, 32'h11);
    tick();
    chk_wr("idle_hold", 1'b1, 4'd3, 32'h11);

    // Sole B write.
    rf.b_valid = 1'b1;
    rf.b_addr  = 4'd4;
    rf.b_data  = 32'h22;
    #1;
    chk_rdy("b_only", 1'b0, 1'b1);
    tick();
    rf.b_valid = 1'b0;
    chk_wr("b_only_wr", 1'b0, 4'd4, 32'h22);

    // Contention held four cycles: A,B,A,B with no bubble.
    rf.a_valid = 1'b1; rf.a_addr = 4'd1; rf.a_data = 32'hA1;
    rf.b_valid = 1'b1; rf.b_addr = 4'd2; rf.b_data = 32'hB2;
    #1;
    chk_rdy("rr0", 1'b1, 1'b0);
    tick();
    chk_wr("rr0_wr", 1'b0, 4'd1, 32'hA1);
    chk_rdy("rr1", 1'b0, 1'b1);
    tick();
    chk_wr("rr1_wr", 1'b0, 4'd2, 32'hB2);
    chk_rdy("rr2", 1'b1, 1'b0);
    tick();
    chk_wr("rr2_wr", 1'b0, 4'd1, 32'hA1);
    chk_rdy("rr3", 1'b0, 1'b1);
    tick();
    rf.a_valid = 1'b0;
    rf.b_valid = 1'b0;
    chk_wr("rr3_wr", 1'b0, 4'd2, 32'hB2);
    tick();
    chk_wr("rr_idle", 1'b1, 4'd2, 32'hB2);

    // Hazard on register 5 until the write to 5 retires.
    rf.addressA    = 4'd5;
    rf.issue_valid = 1'b1;
    rf.issue_addr  = 4'd5;
    #1;
    chk("haz5_pre", {31'd0, rf.hazardA}, 32'd0);
    tick();
    rf.issue_valid = 1'b0;
    chk("haz5_set", {31'd0, rf.hazardA}, {31'd0, SB});
    tick();
    tick();
    chk("haz5_hold", {31'd0, rf.hazardA}, {31'd0, SB});
    rf.a_valid = 1'b1; rf.a_addr = 4'd5; rf.a_data = 32'h55;
    tick();
    rf.a_valid = 1'b0;
    chk_wr("w5", 1'b0, 4'd5, 32'h55);
    chk("haz5_during_wr", {31'd0, rf.hazardA}, {31'd0, SB});
    tick();
    chk("haz5_clear", {31'd0, rf.hazardA}, 32'd0);

    // Issue to 7 on the same edge that retires a write to 7: stays pending.
    rf.addressB = 4'd7;
    rf.a_valid = 1'b1; rf.a_addr = 4'd7; rf.a_data = 32'h77;
    tick();
    rf.a_valid     = 1'b0;
    rf.issue_valid = 1'b1;
    rf.issue_addr  = 4'd7;
    chk_wr("w7", 1'b0, 4'd7, 32'h77);
    chk("haz7_before", {31'd0, rf.hazardB}, 32'd0);
    tick();
    rf.issue_valid = 1'b0;
    chk("haz7_setclr", {31'd0, rf.hazardB}, {31'd0, SB});
    chk("w7_idle_rw", {31'd0, rf.RW}, 32'd1);
    tick();
    chk("haz7_persist", {31'd0, rf.hazardB}, {31'd0, SB});

    // Register 15 behaves like any other.
    rf.addressA    = 4'd15;
    rf.issue_valid = 1'b1;
    rf.issue_addr  = 4'd15;
    tick();
    rf.issue_valid = 1'b0;
    chk("haz15_set", {31'd0, rf.hazardA}, {31'd0, SB});
    rf.b_valid = 1'b1; rf.b_addr = 4'd15; rf.b_data = 32'hF5;
    #1;
    chk_rdy("b15", 1'b0, 1'b1);
    tick();
    rf.b_valid = 1'b0;
    chk_wr("w15", 1'b0, 4'd15, 32'hF5);
    tick();
    chk("haz15_clear", {31'd0, rf.hazardA}, 32'd0);
    chk("haz7_still", {31'd0, rf.hazardB}, {31'd0, SB});

    // Reset the cycle after a grant: registered write is abandoned.
    rf.addressA    = 4'd9;
    rf.issue_valid = 1'b1;
    rf.issue_addr  = 4'd9;
    tick();
    rf.issue_valid = 1'b0;
    chk("haz9_set", {31'd0, rf.hazardA}, {31'd0, SB});
    rf.a_valid = 1'b1; rf.a_addr = 4'd9; rf.a_data = 32'h99;
    tick();
    rf.a_valid = 1'b0;
    CLR = 1'b0;
    #1;
    chk_wr("rst_mid", 1'b1, 4'd0, 32'h0);
    chk("rst_mid_hazA", {31'd0, rf.hazardA}, 32'd0);
    chk("rst_mid_hazB", {31'd0, rf.hazardB}, 32'd0);
    rf.a_valid = 1'b1;
    rf.b_valid = 1'b1;
    rf.b_addr  = 4'd8;
    rf.b_data  = 32'h88;
    #1;
    chk_rdy("rst_mid", 1'b0, 1'b0);
    tick();
    chk_wr("rst_held", 1'b1, 4'd0, 32'h0);
    @(negedge CLK);
    CLR = 1'b1;
    #1;
    chk_rdy("post_rst", 1'b1, 1'b0);
    chk("post_rst_haz9", {31'd0, rf.hazardA}, 32'd0);
    tick();
    rf.a_valid = 1'b0;
    rf.b_valid = 1'b0;
    chk_wr("post_rst_wr", 1'b0, 4'd9, 32'h99);
    tick();
    chk_wr("post_rst_idle", 1'b1, 4'd9, 32'h99);

    // Hazard on port B for register 2.
    rf.addressB    = 4'd2;
    rf.issue_valid = 1'b1;
    rf.issue_addr  = 4'd2;
    #1;
    chk("haz2_pre", {31'd0, rf.hazardB}, 32'd0);
    tick();
    rf.issue_valid = 1'b0;
    chk("haz2_set", {31'd0, rf.hazardB}, {31'd0, SB});
    tick();
    chk("haz2_hold", {31'd0, rf.hazardB}, {31'd0, SB});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
